fnd_scan_controller: RTL and testbench
======================================

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 Parameter CLK_DIV, default 100000: clock cycles per digit slot, DEAD_CYCLES+1 to 2^20.
REQ-002 Parameter DEAD_CYCLES, default 16: all-off cycles at the start of each slot, 1 to CLK_DIV-1.
REQ-003 Parameter BLINK_FRAMES, default 125: complete frames per blink half-period, at least 1.
REQ-004 i_clk  input  1  single system clock, rising-edge.
REQ-005 i_reset  input  1  synchronous, active-low reset.
REQ-006 i_enable  input  1  1 = scanning runs; 0 = display off, counters held.
REQ-007 i_blank_mask  input  4  bit k=1 forces digit k dark.
REQ-008 i_blink_mask  input  4  bit k=1 makes digit k dark while blink phase is 1.
REQ-009 i_dp_mask  input  4  bit k=1 lights the decimal point while digit k is driven.
REQ-010 o_digitPosition  output  2  digit select driven to the 4:1 digit-value mux.
REQ-011 o_fndCom  output  4  active-low digit commons; at most one bit low.
REQ-012 o_dp  output  1  active-high decimal-point drive.
REQ-013 o_frame_done  output  1  one-cycle pulse at the end of each 4-digit frame.
REQ-014 o_blink_phase  output  1  current blink phase.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, DEAD and DRIVE.
REQ-016 All outputs SHALL be registered; every input affects the outputs one cycle after it is sampled.
REQ-017 In IDLE: o_fndCom=4'b1111, o_dp=0, o_digitPosition=0, slot counter=0; IDLE -> DEAD when i_enable=1.
REQ-018 In DEAD: o_fndCom=4'b1111, o_dp=0; DEAD lasts exactly DEAD_CYCLES cycles, then -> DRIVE.
REQ-019 In DRIVE, with p = o_digitPosition: o_fndCom[p]=0 unless i_blank_mask[p]=1 or (i_blink_mask[p]=1 and o_blink_phase=1); all other commons stay 1.
REQ-020 In DRIVE, o_dp = i_dp_mask[p] when digit p is lit, else 0.
REQ-021 DRIVE lasts exactly CLK_DIV-DEAD_CYCLES cycles, so one slot is CLK_DIV cycles and one frame is 4*CLK_DIV cycles.
REQ-022 At the end of DRIVE: o_digitPosition advances 0->1->2->3->0 (mod-4 wrap) on the same edge as DRIVE -> DEAD.
REQ-023 o_digitPosition SHALL change only at a DRIVE->DEAD edge or on a return to IDLE, never while any common is low.
REQ-024 At the end of DRIVE with p=3: o_frame_done=1 for exactly one cycle, coincident with the first DEAD cycle of the next frame.
REQ-025 A frame counter SHALL count frame_done events; on the BLINK_FRAMES-th event it clears and o_blink_phase toggles on the same edge as o_frame_done.
REQ-026 i_enable=0 in any state -> IDLE on the next edge; slot and frame counters clear.
REQ-027 While in IDLE, o_blink_phase SHALL hold its value, and no o_frame_done pulse SHALL be emitted.
REQ-028 i_enable re-asserted: scanning SHALL restart at digit 0 with a full DEAD period.
REQ-029 Mask inputs SHALL be sampled every cycle; a mask change during DRIVE takes effect on the next edge, with no slot restart.
REQ-030 Counters SHALL saturate/wrap only as specified; no X or out-of-range position may ever appear.

Reset
REQ-031 i_reset=0 at a rising edge: state=IDLE, o_digitPosition=0, o_fndCom=4'b1111, o_dp=0, o_frame_done=0, o_blink_phase=0, all counters=0.
REQ-032 Reset SHALL take priority over i_enable and abort any slot in progress.
REQ-033 The first DEAD cycle SHALL follow the first edge with i_reset=1 and i_enable=1.

Verification
Bench parameters: CLK_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2; masks 0 unless stated.
REQ-034 Basic scan -> 2 cycles 1111; 6 cycles 1110 at position 0; then 2 cycles 1111; 6 cycles 1101 at position 1; ... through 0111 at position 3; first frame_done at cycle 32 after enable.
REQ-035 Blink, i_blink_mask=4'b0100 -> o_blink_phase toggles every 2nd frame_done; while phase=1, digit 2 slot shows 1111 and the other digits are unaffected.
REQ-036 i_blank_mask=4'b0001 and i_dp_mask=4'b0011 -> digit 0 slot all 1111 with o_dp=0; digit 1 lit with o_dp=1.
REQ-037 Drop i_enable mid-DRIVE at position 2 -> next edge 1111, position 0; re-enable -> restart at position 0 with a 2-cycle DEAD, blink phase unchanged.
REQ-038 Assert i_reset=0 mid-frame with phase=1 -> next edge: all REQ-031 values; no frame_done pulse.
REQ-039 Every cycle, assert at most one o_fndCom bit is low, and that o_digitPosition is stable while any common is low.

Source files
------------

// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed 7-segment common scanner with dead-time, blanking,
// blinking and decimal-point control. All outputs are registered.
module fnd_scan_controller #(
  parameter int CLK_DIV      = 100000,
  parameter int DEAD_CYCLES  = 16,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [3:0] i_blank_mask,
  input  logic [3:0] i_blink_mask,
  input  logic [3:0] i_dp_mask,
  output logic [1:0] o_digitPosition,
  output logic [3:0] o_fndCom,
  output logic       o_dp,
  output logic       o_frame_done,
  output logic       o_blink_phase
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [19:0]   DEAD_LAST  = 20'(DEAD_CYCLES - 1);
  localparam logic [19:0]   DRIVE_LAST = 20'(CLK_DIV - DEAD_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0] FRAME_ONE  = FW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [19:0]   cnt_q, cnt_d;
  logic [1:0]    pos_q, pos_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          blink_q, blink_d;
  logic          frame_done_q, frame_done_d;
  logic [3:0]    com_q, com_d;
  logic          dp_q, dp_d;
  logic [3:0]    lit;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pos_d        = pos_q;
    frame_d      = frame_q;
    blink_d      = blink_q;
    frame_done_d = 1'b0;
    if (!i_enable) begin
      // Disabling parks the scanner but keeps the blink phase for the restart.
      state_d = IDLE;
      cnt_d   = '0;
      pos_d   = 2'd0;
      frame_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DEAD;
          cnt_d   = '0;
          pos_d   = 2'd0;
        end
        DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 20'd1;
          end
        end
        DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = DEAD;
            cnt_d   = '0;
            pos_d   = pos_q + 2'd1;
            if (pos_q == 2'd3) begin
              frame_done_d = 1'b1;
              if (frame_q == FRAME_LAST) begin
                frame_d = '0;
                blink_d = ~blink_q;
              end else begin
                frame_d = frame_q + FRAME_ONE;
              end
            end
          end else begin
            cnt_d = cnt_q + 20'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          pos_d   = 2'd0;
          frame_d = '0;
        end
      endcase
    end
  end

  // Commons are decoded from the next state so they line up with the registered position.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign lit[gi] = (state_d == DRIVE) && (pos_d == 2'(gi)) &&
                       !i_blank_mask[gi] && !(i_blink_mask[gi] && blink_d);
    end
  endgenerate

  assign com_d = ~lit;
  assign dp_d  = |(lit & i_dp_mask);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pos_q        <= 2'd0;
      frame_q      <= '0;
      blink_q      <= 1'b0;
      frame_done_q <= 1'b0;
      com_q        <= 4'b1111;
      dp_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pos_q        <= pos_d;
      frame_q      <= frame_d;
      blink_q      <= blink_d;
      frame_done_q <= frame_done_d;
      com_q        <= com_d;
      dp_q         <= dp_d;
    end
  end

  assign o_digitPosition = pos_q;
  assign o_fndCom        = com_q;
  assign o_dp            = dp_q;
  assign o_frame_done    = frame_done_q;
  assign o_blink_phase   = blink_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller: a time-since-enable reference
// model predicts every output; directed scenarios plus a randomized soak.
module tb_fnd_scan_controller;

  localparam int CLK_DIV      = 8;
  localparam int DEAD         = 2;
  localparam int BLINK_FRAMES = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] blank = 4'd0;
  logic [3:0] blink = 4'd0;
  logic [3:0] dpm = 4'd0;
  logic [1:0] o_digitPosition;
  logic [3:0] o_fndCom;
  logic       o_dp, o_frame_done, o_blink_phase;

  int checks = 0;
  int errors = 0;

  // Reference model state: k = consecutive enabled edges since the last stop.
  int         k = 0;
  int         frames = 0;
  int         cyc = 0;
  logic       m_phase = 1'b0;
  logic       m_fd = 1'b0;
  logic       m_dp = 1'b0;
  logic [1:0] m_pos = 2'd0;
  logic [3:0] m_com = 4'hF;

  logic       mon_en = 1'b0;
  logic       prev_low = 1'b0;
  logic [1:0] prev_pos = 2'd0;

  fnd_scan_controller #(
    .CLK_DIV(CLK_DIV),
    .DEAD_CYCLES(DEAD),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_enable(en),
    .i_blank_mask(blank),
    .i_blink_mask(blink),
    .i_dp_mask(dpm),
    .o_digitPosition(o_digitPosition),
    .o_fndCom(o_fndCom),
    .o_dp(o_dp),
    .o_frame_done(o_frame_done),
    .o_blink_phase(o_blink_phase)
  );

  always #5 clk = ~clk;

  // One clock edge; the model derives expected outputs from the sampled inputs.
  task automatic tick();
    int off;
    @(posedge clk);
    if (!rst_n) begin
      k = 0; frames = 0; m_phase = 1'b0;
    end else if (!en) begin
      k = 0; frames = 0;
    end else begin
      k++;
    end
    m_fd = 1'b0; m_pos = 2'd0; m_com = 4'hF; m_dp = 1'b0;
    if (rst_n && en) begin
      off = k - 1;
      m_pos = 2'((off / CLK_DIV) % 4);
      if (off > 0 && (off % (4 * CLK_DIV)) == 0) begin
        m_fd = 1'b1;
        frames++;
        if (frames == BLINK_FRAMES) begin
          frames = 0;
          m_phase = ~m_phase;
        end
      end
      if ((off % CLK_DIV) >= DEAD && !blank[m_pos] && !(blink[m_pos] && m_phase)) begin
        m_com[m_pos] = 1'b0;
        m_dp = dpm[m_pos];
      end
    end
    cyc++;
    #1;
  endtask

  // Continuous properties: one common at most, position frozen while lit.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ($countones(~o_fndCom) > 1) begin
        errors++;
        $display("FAIL onehot_com cyc %0d: got com=%b, required at most one low bit", cyc, o_fndCom);
      end
      if (prev_low && o_fndCom != 4'hF) begin
        checks++;
        if (o_digitPosition !== prev_pos) begin
          errors++;
          $display("FAIL pos_stable cyc %0d: got pos=%0d, required %0d", cyc, o_digitPosition, prev_pos);
        end
      end
      prev_low <= (o_fndCom != 4'hF);
      prev_pos <= o_digitPosition;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    tick(); tick();
    checks++;
    if ({o_fndCom, o_dp, o_frame_done, o_digitPosition, o_blink_phase} !== {4'hF, 1'b0, 1'b0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got com=%b dp=%b fd=%b pos=%0d ph=%b, required 1111 0 0 0 0",
               o_fndCom, o_dp, o_frame_done, o_digitPosition, o_blink_phase);
    end
    en = 1'b0; rst_n = 1'b1;
    tick();
    checks++;
    if (o_fndCom !== 4'hF || o_digitPosition !== 2'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got com=%b pos=%0d, required 1111 0", o_fndCom, o_digitPosition);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_basic_scan();
    int first_fd = -1;
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({o_fndCom, o_dp, o_frame_done, o_digitPosition, o_blink_phase} !== {m_com, m_dp, m_fd, m_pos, m_phase}) begin
        errors++;
        $display("FAIL basic_scan i=%0d: got com=%b dp=%b fd=%b pos=%0d ph=%b, expected com=%b dp=%b fd=%b pos=%0d ph=%b",
                 i, o_fndCom, o_dp, o_frame_done, o_digitPosition, o_blink_phase, m_com, m_dp, m_fd, m_pos, m_phase);
      end
      if (o_frame_done === 1'b1 && first_fd < 0) first_fd = i;
    end
    checks++;
    if (first_fd != 32) begin
      errors++;
      $display("FAIL first_frame_done: got cycle %0d, required 32", first_fd);
    end
  endtask

  task automatic test_blink();
    int toggles = 0;
    int dig2_lit_ph1 = 0;
    logic last_ph;
    en = 1'b0; tick();
    blink = 4'b0100; en = 1'b1;
    last_ph = o_blink_phase;
    for (int i = 0; i < 132; i++) begin
      tick();
      checks++;
      if ({o_fndCom, o_dp, o_frame_done, o_digitPosition, o_blink_phase} !== {m_com, m_dp, m_fd, m_pos, m_phase}) begin
        errors++;
        $display("FAIL blink i=%0d: got com=%b fd=%b pos=%0d ph=%b, expected com=%b fd=%b pos=%0d ph=%b",
                 i, o_fndCom, o_frame_done, o_digitPosition, o_blink_phase, m_com, m_fd, m_pos, m_phase);
      end
      if (o_blink_phase !== last_ph) toggles++;
      last_ph = o_blink_phase;
      if (o_blink_phase === 1'b1 && o_fndCom[2] === 1'b0) dig2_lit_ph1++;
    end
    checks++;
    if (toggles != 2) begin
      errors++;
      $display("FAIL blink_toggles: got %0d, required 2", toggles);
    end
    checks++;
    if (dig2_lit_ph1 != 0) begin
      errors++;
      $display("FAIL blink_dark: got %0d lit digit-2 cycles in phase 1, required 0", dig2_lit_ph1);
    end
    blink = 4'd0;
  endtask

  task automatic test_blank_dp();
    int dp1 = 0;
    int lit0 = 0;
    en = 1'b0; tick();
    blank = 4'b0001; dpm = 4'b0011; en = 1'b1;
    for (int i = 0; i < 34; i++) begin
      tick();
      checks++;
      if ({o_fndCom, o_dp, o_digitPosition} !== {m_com, m_dp, m_pos}) begin
        errors++;
        $display("FAIL blank_dp i=%0d: got com=%b dp=%b pos=%0d, expected com=%b dp=%b pos=%0d",
                 i, o_fndCom, o_dp, o_digitPosition, m_com, m_dp, m_pos);
      end
      if (o_fndCom[0] === 1'b0 || (o_digitPosition == 2'd0 && o_dp === 1'b1)) lit0++;
      if (o_digitPosition == 2'd1 && o_dp === 1'b1) dp1++;
    end
    checks++;
    if (lit0 != 0) begin
      errors++;
      $display("FAIL blank_digit0: got %0d lit cycles, required 0", lit0);
    end
    checks++;
    if (dp1 != 6) begin
      errors++;
      $display("FAIL dp_digit1: got %0d dp cycles, required 6", dp1);
    end
    blank = 4'd0; dpm = 4'd0;
  endtask

  task automatic test_enable_drop();
    int n = 0;
    logic saved_ph;
    en = 1'b1;
    while (!(o_digitPosition == 2'd2 && o_fndCom == 4'b1011) && n < 200) begin
      tick(); n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drop_wait: got no digit-2 drive in 200 cycles, required one");
    end
    saved_ph = m_phase;
    en = 1'b0; tick();
    checks++;
    if ({o_fndCom, o_dp, o_digitPosition, o_frame_done} !== {4'hF, 1'b0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL drop_idle: got com=%b dp=%b pos=%0d fd=%b, required 1111 0 0 0",
               o_fndCom, o_dp, o_digitPosition, o_frame_done);
    end
    tick();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({o_fndCom, o_digitPosition, o_blink_phase} !== {(i < 2) ? 4'hF : 4'hE, 2'd0, saved_ph}) begin
        errors++;
        $display("FAIL restart i=%0d: got com=%b pos=%0d ph=%b, required com=%b pos=0 ph=%b",
                 i, o_fndCom, o_digitPosition, o_blink_phase, (i < 2) ? 4'hF : 4'hE, saved_ph);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    en = 1'b1;
    while (o_blink_phase !== 1'b1 && n < 300) begin
      tick(); n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL phase_wait: got phase 0 for 300 cycles, required 1");
    end
    for (int i = 0; i < 13; i++) tick();
    rst_n = 1'b0; tick();
    checks++;
    if ({o_fndCom, o_dp, o_frame_done, o_digitPosition, o_blink_phase} !== {4'hF, 1'b0, 1'b0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got com=%b dp=%b fd=%b pos=%0d ph=%b, required 1111 0 0 0 0",
               o_fndCom, o_dp, o_frame_done, o_digitPosition, o_blink_phase);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({o_fndCom, o_digitPosition, o_frame_done} !== {(i < 2) ? 4'hF : 4'hE, 2'd0, 1'b0}) begin
        errors++;
        $display("FAIL post_reset i=%0d: got com=%b pos=%0d fd=%b, required com=%b pos=0 fd=0",
                 i, o_fndCom, o_digitPosition, o_frame_done, (i < 2) ? 4'hF : 4'hE);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      en    = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 9) == 0) blank = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) blink = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) dpm   = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if ({o_fndCom, o_dp, o_frame_done, o_digitPosition, o_blink_phase} !== {m_com, m_dp, m_fd, m_pos, m_phase}) begin
        errors++;
        $display("FAIL random i=%0d: got com=%b dp=%b fd=%b pos=%0d ph=%b, expected com=%b dp=%b fd=%b pos=%0d ph=%b",
                 i, o_fndCom, o_dp, o_frame_done, o_digitPosition, o_blink_phase, m_com, m_dp, m_fd, m_pos, m_phase);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_blink();
    test_blank_dp();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
